// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, complex/twiddle types
// and the output saturation helper.
package fft_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 15;

    // Wide enough for any intermediate that is handed to saturate()
    localparam int SAT_IN_W = 48;

    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'((64'sd1 <<< (DEF_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef logic [1:0][DEF_DATA_WIDTH-1:0] cplx_t;
    typedef logic [1:0][DEF_FRAC_BITS:0]    twid_t;

    typedef struct packed {
        logic                      ovf;
        logic [DEF_DATA_WIDTH-1:0] val;
    } sat_t;

    function automatic sat_t saturate(input logic signed [SAT_IN_W-1:0] x);
        sat_t r;
        r.ovf = 1'b0;
        r.val = x[DEF_DATA_WIDTH-1:0];
        if (x > SAT_MAX) begin
            r.ovf = 1'b1;
            r.val = SAT_MAX[DEF_DATA_WIDTH-1:0];
        end else if (x < SAT_MIN) begin
            r.ovf = 1'b1;
            r.val = SAT_MIN[DEF_DATA_WIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_conj_pipe.sv
// Two-stage conjugate complex multiply: full-width products, then sum,
// floor shift by FRAC_BITS and saturation. The sum path is forwarded alongside.
module cmul_conj_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic [1:0][DATA_WIDTH:0]   d_i,
    input  logic [1:0][DATA_WIDTH:0]   s_i,
    input  logic [1:0][FRAC_BITS:0]    twid_i,
    output logic                       valid_o,
    output logic [1:0][DATA_WIDTH-1:0] a_o,
    output logic [1:0][DATA_WIDTH-1:0] b_o,
    output logic                       sat_o
);

    localparam int PW = DATA_WIDTH + FRAC_BITS + 2;
    localparam int SW = PW + 1;

    logic signed [PW-1:0]       p_rr_d, p_rr_q, p_ii_d, p_ii_q;
    logic signed [PW-1:0]       p_ir_d, p_ir_q, p_ri_d, p_ri_q;
    logic [1:0][DATA_WIDTH:0]   s2_d, s2_q;
    logic                       v2_d, v2_q;
    logic signed [SW-1:0]       re_sum, im_sum, re_sh, im_sh;
    sat_t                       sat_re, sat_im, sat_s_re, sat_s_im;
    logic [1:0][DATA_WIDTH-1:0] a_d, a_q, b_d, b_q;
    logic                       v3_d, v3_q;

    // Products are formed at full width so that (-1)*(-1) cannot wrap
    always_comb begin
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ir_d = p_ir_q;
        p_ri_d = p_ri_q;
        s2_d   = s2_q;
        v2_d   = v2_q;
        if (en_i) begin
            p_rr_d = PW'($signed(d_i[0])) * PW'($signed(twid_i[0]));
            p_ii_d = PW'($signed(d_i[1])) * PW'($signed(twid_i[1]));
            p_ir_d = PW'($signed(d_i[1])) * PW'($signed(twid_i[0]));
            p_ri_d = PW'($signed(d_i[0])) * PW'($signed(twid_i[1]));
            s2_d   = s_i;
            v2_d   = valid_i;
        end
    end

    always_comb begin
        re_sum   = SW'(p_rr_q) + SW'(p_ii_q);
        im_sum   = SW'(p_ir_q) - SW'(p_ri_q);
        re_sh    = re_sum >>> FRAC_BITS;
        im_sh    = im_sum >>> FRAC_BITS;
        sat_re   = saturate(SAT_IN_W'(re_sh));
        sat_im   = saturate(SAT_IN_W'(im_sh));
        sat_s_re = saturate(SAT_IN_W'($signed(s2_q[0])));
        sat_s_im = saturate(SAT_IN_W'($signed(s2_q[1])));
        sat_o    = v2_q & (sat_re.ovf | sat_im.ovf | sat_s_re.ovf | sat_s_im.ovf);
        a_d      = a_q;
        b_d      = b_q;
        v3_d     = v3_q;
        if (en_i) begin
            a_d  = {sat_s_im.val, sat_s_re.val};
            b_d  = {sat_im.val, sat_re.val};
            v3_d = v2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ir_q <= '0;
            p_ri_q <= '0;
            s2_q   <= '0;
            v2_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            v3_q   <= 1'b0;
        end else begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ir_q <= p_ir_d;
            p_ri_q <= p_ri_d;
            s2_q   <= s2_d;
            v2_q   <= v2_d;
            a_q    <= a_d;
            b_q    <= b_d;
            v3_q   <= v3_d;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign valid_o = v3_q;

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Inverse radix-2 butterfly: a = A+B, b = (A-B)*conj(w), three register
// stages under one global advance, saturating outputs and sticky overflow.
module ifft_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0][FRAC_BITS:0]    twid_i,
    input  logic [1:0][DATA_WIDTH-1:0] a_i,
    input  logic [1:0][DATA_WIDTH-1:0] b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [1:0][DATA_WIDTH-1:0] a_o,
    output logic [1:0][DATA_WIDTH-1:0] b_o,
    output logic                       ovf_o,
    input  logic                       clr_ovf_i
);

    logic                     adv;
    logic                     v1_d, v1_q;
    logic [1:0][DATA_WIDTH:0] s1_d, s1_q, d1_d, d1_q;
    logic [1:0][FRAC_BITS:0]  tw1_d, tw1_q;
    logic                     sat;
    logic                     ovf_d, ovf_q;

    // No skid buffer: upstream ready is a combinational function of out_ready_i
    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        v1_d  = v1_q;
        s1_d  = s1_q;
        d1_d  = d1_q;
        tw1_d = tw1_q;
        if (adv) begin
            v1_d  = in_valid_i;
            tw1_d = twid_i;
            for (int i = 0; i < 2; i++) begin
                s1_d[i] = (DATA_WIDTH+1)'($signed(a_i[i])) + (DATA_WIDTH+1)'($signed(b_i[i]));
                d1_d[i] = (DATA_WIDTH+1)'($signed(a_i[i])) - (DATA_WIDTH+1)'($signed(b_i[i]));
            end
        end
    end

    // A set in the same cycle as a clear takes priority
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if (adv && sat) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q  <= 1'b0;
            s1_q  <= '0;
            d1_q  <= '0;
            tw1_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            s1_q  <= s1_d;
            d1_q  <= d1_d;
            tw1_q <= tw1_d;
            ovf_q <= ovf_d;
        end
    end

    cmul_conj_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_cmul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (adv),
        .valid_i (v1_q),
        .d_i     (d1_q),
        .s_i     (s1_q),
        .twid_i  (tw1_q),
        .valid_o (out_valid_o),
        .a_o     (a_o),
        .b_o     (b_o),
        .sat_o   (sat)
    );

    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Scoreboard bench for ifft_butterfly_pipe: the driver issues transfers, the
// monitor pushes model results on acceptance and pops/compares on output.
module tb_ifft_butterfly_pipe;
    import fft_pkg::*;

    localparam longint DMAX = (64'sd1 <<< (DEF_DATA_WIDTH - 1)) - 1;
    localparam longint DMIN = -DMAX - 1;
    localparam longint ONE  = 64'sd1 <<< DEF_FRAC_BITS;

    typedef struct {
        longint a_re, a_im, b_re, b_im;
        bit     sat;
        int     in_cyc;
    } exp_t;

    logic  clk_i = 1'b0;
    logic  rst_ni, in_valid_i, in_ready_o, out_valid_o, out_ready_i, ovf_o, clr_ovf_i;
    twid_t twid_i;
    cplx_t a_i, b_i, a_o, b_o;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    n_popped = 0;
    bit    strict_lat = 1'b0;
    bit    sticky_m   = 1'b0;
    bit    hold_pending = 1'b0;
    cplx_t held_a, held_b;
    exp_t  sb_q[$];
    exp_t  e_pop;

    ifft_butterfly_pipe dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .twid_i      (twid_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_o         (a_o),
        .b_o         (b_o),
        .ovf_o       (ovf_o),
        .clr_ovf_i   (clr_ovf_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic longint clamp(input longint x);
        if (x > DMAX) return DMAX;
        if (x < DMIN) return DMIN;
        return x;
    endfunction

    function automatic bit out_of_range(input longint x);
        return (x > DMAX) || (x < DMIN);
    endfunction

    // Reference: a = A+B, b = floor((A-B)*conj(w) / 2^FRAC_BITS), both clamped
    function automatic exp_t model(input cplx_t a, input cplx_t b, input twid_t w, input int c);
        exp_t   e;
        longint s_re, s_im, d_re, d_im, w_re, w_im, q_re, q_im;
        s_re = longint'($signed(a[0])) + longint'($signed(b[0]));
        s_im = longint'($signed(a[1])) + longint'($signed(b[1]));
        d_re = longint'($signed(a[0])) - longint'($signed(b[0]));
        d_im = longint'($signed(a[1])) - longint'($signed(b[1]));
        w_re = longint'($signed(w[0]));
        w_im = longint'($signed(w[1]));
        q_re = floor_div(d_re * w_re + d_im * w_im, ONE);
        q_im = floor_div(d_im * w_re - d_re * w_im, ONE);
        e.a_re   = clamp(s_re);
        e.a_im   = clamp(s_im);
        e.b_re   = clamp(q_re);
        e.b_im   = clamp(q_im);
        e.sat    = out_of_range(s_re) | out_of_range(s_im) | out_of_range(q_re) | out_of_range(q_im);
        e.in_cyc = c;
        return e;
    endfunction

    // Monitor: every transfer is decided by the values stable at the falling edge
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_output("hold_valid", longint'(out_valid_o), 1);
                check_output("hold_a", longint'(a_o), longint'(held_a));
                check_output("hold_b", longint'(b_o), longint'(held_b));
            end
            hold_pending = out_valid_o && !out_ready_i;
            held_a = a_o;
            held_b = b_o;
            if (out_valid_o && !out_ready_i) begin
                check_output("in_ready_stall", longint'(in_ready_o), 0);
            end
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_output", 1, 0);
                end else begin
                    e_pop = sb_q.pop_front();
                    n_popped++;
                    sticky_m = sticky_m | e_pop.sat;
                    check_output("a_re", longint'($signed(a_o[0])), e_pop.a_re);
                    check_output("a_im", longint'($signed(a_o[1])), e_pop.a_im);
                    check_output("b_re", longint'($signed(b_o[0])), e_pop.b_re);
                    check_output("b_im", longint'($signed(b_o[1])), e_pop.b_im);
                    check_output("ovf", longint'(ovf_o), longint'(sticky_m));
                    if (strict_lat) begin
                        check_output("latency", longint'(cyc - e_pop.in_cyc), 3);
                    end
                end
            end
            if (in_valid_i && in_ready_o) begin
                sb_q.push_back(model(a_i, b_i, twid_i, cyc));
            end
        end
    end

    task automatic set_inputs(input int ar, input int ai, input int br, input int bi,
                              input int wr, input int wi);
        a_i[0] = 16'(ar);
        a_i[1] = 16'(ai);
        b_i[0] = 16'(br);
        b_i[1] = 16'(bi);
        twid_i[0] = 16'(wr);
        twid_i[1] = 16'(wi);
    endtask

    task automatic apply_stimulus(input int ar, input int ai, input int br, input int bi,
                                  input int wr, input int wi);
        @(posedge clk_i); #2;
        set_inputs(ar, ai, br, bi, wr, wi);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i); #2;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk_i); #2;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk_i);
        end
        #2;
        check_output("drain_empty", longint'(sb_q.size()), 0);
    endtask

    task automatic clear_ovf();
        @(posedge clk_i); #2;
        clr_ovf_i = 1'b1;
        @(posedge clk_i); #2;
        clr_ovf_i = 1'b0;
        sticky_m  = 1'b0;
        check_output("ovf_cleared", longint'(ovf_o), 0);
    endtask

    task automatic random_inputs();
        set_inputs(int'($urandom_range(65535)), int'($urandom_range(65535)),
                   int'($urandom_range(65535)), int'($urandom_range(65535)),
                   int'($urandom_range(65535)), int'($urandom_range(65535)));
        case ($urandom_range(15))
            0: begin twid_i[0] = 16'h8000; twid_i[1] = 16'h0000; end
            1: begin twid_i[0] = 16'h0000; twid_i[1] = 16'h8000; end
            default: ;
        endcase
    endtask

    // mode 1: valid every cycle, out_ready low for stream cycles 4..9; mode 0: random
    task automatic run_stream(input int n_items, input int mode);
        int sent = 0;
        int t = 0;
        bit pending = 1'b0;
        while (sent < n_items && t < n_items * 10 + 100) begin
            @(posedge clk_i); #2;
            if (!pending) begin
                if (mode == 1 || $urandom_range(3) != 0) begin
                    random_inputs();
                    in_valid_i = 1'b1;
                    pending    = 1'b1;
                end else begin
                    in_valid_i = 1'b0;
                end
            end
            if (mode == 1) out_ready_i = !(t >= 4 && t <= 9);
            else           out_ready_i = ($urandom_range(3) != 0);
            @(negedge clk_i);
            if (in_valid_i && in_ready_o) begin
                sent++;
                pending = 1'b0;
            end
            t++;
        end
        check_output("stream_sent", longint'(sent), longint'(n_items));
        @(posedge clk_i); #2;
        in_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        clr_ovf_i   = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        #3;
        check_output("rst_out_valid", longint'(out_valid_o), 0);
        check_output("rst_a_o", longint'(a_o), 0);
        check_output("rst_b_o", longint'(b_o), 0);
        check_output("rst_ovf", longint'(ovf_o), 0);
        check_output("rst_in_ready", longint'(in_ready_o), 1);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        strict_lat = 1'b1;
        apply_stimulus(1000, 200, 600, -100, 32767, 0);
        drain();
        check_output("unity_ovf", longint'(ovf_o), 0);
        apply_stimulus(1000, 200, 600, -100, 0, -32768);
        drain();
        apply_stimulus(32767, 0, 1, 0, 32767, 0);
        drain();
        check_output("sat_ovf", longint'(ovf_o), 1);
        apply_stimulus(-32768, 0, 0, 0, -32768, 0);
        drain();
        clear_ovf();

        // Clear asserted in exactly the cycle the saturating result enters the output stage
        @(posedge clk_i); #2;
        set_inputs(32767, 0, 1, 0, 32767, 0);
        in_valid_i = 1'b1;
        @(posedge clk_i); #2;
        in_valid_i = 1'b0;
        @(posedge clk_i); #2;
        clr_ovf_i = 1'b1;
        @(posedge clk_i); #2;
        clr_ovf_i = 1'b0;
        check_output("ovf_set_wins", longint'(ovf_o), 1);
        drain();
        clear_ovf();

        strict_lat = 1'b0;
        base = n_popped;
        run_stream(8, 1);
        drain();
        check_output("bp_count", longint'(n_popped - base), 8);

        strict_lat = 1'b1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #2;
            if (k == 0) set_inputs(32767, 0, 1, 0, 32767, 0);
            else        random_inputs();
            in_valid_i = 1'b1;
        end
        @(posedge clk_i); #2;
        in_valid_i = 1'b0;
        check_output("pre_rst_valid", longint'(out_valid_o), 1);
        check_output("pre_rst_ovf", longint'(ovf_o), 1);
        rst_ni = 1'b0;
        #1;
        check_output("mid_rst_valid", longint'(out_valid_o), 0);
        check_output("mid_rst_a_o", longint'(a_o), 0);
        check_output("mid_rst_b_o", longint'(b_o), 0);
        check_output("mid_rst_ovf", longint'(ovf_o), 0);
        check_output("flushed", longint'(sb_q.size()), 3);
        sb_q.delete();
        sticky_m = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        base = n_popped;
        apply_stimulus(-1234, 4321, 777, -888, 23170, -23170);
        drain();
        check_output("post_rst_count", longint'(n_popped - base), 1);

        strict_lat = 1'b0;
        base = n_popped;
        run_stream(10000, 0);
        drain();
        check_output("rand_count", longint'(n_popped - base), 10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
